vga_rect_arbiter: RTL and testbench

- Shares the single vga_adapter pixel-write port (x, y, colour, plot) between NREQ rectangle-fill requesters: snake draw, snake erase and apple draw.
- Each requester asks for one filled rectangle. The block grants requesters round-robin, rasters the granted rectangle at one pixel per cycle, clips it to the 160x120 screen, and pulses done to that requester.
- It replaces the per-object XC/YC counters and the draw/erase sequencing in the top level.

---
 rtl/vga_rect_arbiter_pkg.sv | 21 ++
 rtl/vga_rect_arbiter_if.sv | 32 +++
 rtl/vga_rect_arbiter_rr_arbiter.sv | 35 +++
 rtl/vga_rect_arbiter.sv | 168 ++++++++++++++++
 tb/tb_vga_rect_arbiter.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_rect_arbiter_pkg.sv
// rtl/vga_rect_arbiter_pkg.sv - shared screen geometry, widths, state and requester constants
package vga_pkg;

    localparam int XSCREEN = 160;
    localparam int YSCREEN = 120;
    localparam int CW      = 3;
    localparam int XW      = 8;
    localparam int YW      = 7;

    localparam int SNAKE_DRAW  = 0;
    localparam int SNAKE_ERASE = 1;
    localparam int APPLE       = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DRAW = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/vga_rect_arbiter_if.sv
// rtl/vga_rect_arbiter_if.sv - requester and vga_adapter signal bundle for the rectangle arbiter
interface vga_rect_arbiter_if #(
    parameter int NREQ = 3,
    parameter int DW   = 5
);
    import vga_pkg::*;

    logic [NREQ-1:0]    req;
    logic [XW*NREQ-1:0] rect_x;
    logic [YW*NREQ-1:0] rect_y;
    logic [DW*NREQ-1:0] rect_w;
    logic [DW*NREQ-1:0] rect_h;
    logic [CW*NREQ-1:0] rect_colour;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    done;
    logic               busy;
    logic [XW-1:0]      vga_x;
    logic [YW-1:0]      vga_y;
    logic [CW-1:0]      vga_colour;
    logic               vga_plot;

    modport master (
        output req, rect_x, rect_y, rect_w, rect_h, rect_colour,
        input  grant, done, busy, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  req, rect_x, rect_y, rect_w, rect_h, rect_colour,
        output grant, done, busy, vga_x, vga_y, vga_colour, vga_plot
    );

endinterface

// File: rtl/vga_rect_arbiter_rr_arbiter.sv
// rtl/vga_rect_arbiter_rr_arbiter.sv - combinational round-robin one-hot picker
module rr_arbiter #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [NREQ-1:0] last_i,
    output logic [NREQ-1:0] grant_o
);

    int   last_idx;
    logic found;

    // Search indices above the last-served one first, then wrap to the low end.
    always_comb begin
        grant_o  = '0;
        found    = 1'b0;
        last_idx = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (last_i[i]) last_idx = i;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_i[i] && (i > last_idx)) begin
                grant_o[i] = 1'b1;
                found      = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_i[i] && (i <= last_idx)) begin
                grant_o[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_rect_arbiter.sv
// rtl/vga_rect_arbiter.sv - round-robin shared vga_adapter port, rasters one clipped filled rectangle per grant
module vga_rect_arbiter
    import vga_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int MAXDIM = 16,
    parameter int DW     = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    vga_rect_arbiter_if.slave bus
);

    state_e          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d, last_q, last_d, rr_pick;
    logic [XW-1:0]   x_q, x_d, sel_x, base_x, vga_x_q, vga_x_d;
    logic [YW-1:0]   y_q, y_d, sel_y, base_y, vga_y_q, vga_y_d;
    logic [DW-1:0]   w_q, w_d, h_q, h_d, sel_w, sel_h, w_clamp, h_clamp;
    logic [DW-1:0]   cx_q, cx_d, cy_q, cy_d, nxt_cx, nxt_cy;
    logic [CW-1:0]   col_q, col_d, sel_col, base_col, vga_col_q, vga_col_d;
    logic            plot_q, plot_d, last_col, last_pix, pix_on, emit;
    logic [XW:0]     sum_x;
    logic [YW:0]     sum_y;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req_i   (bus.req),
        .last_i  (last_q),
        .grant_o (rr_pick)
    );

    always_comb begin
        sel_x   = '0;
        sel_y   = '0;
        sel_w   = '0;
        sel_h   = '0;
        sel_col = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                sel_x   = bus.rect_x[i*XW +: XW];
                sel_y   = bus.rect_y[i*YW +: YW];
                sel_w   = bus.rect_w[i*DW +: DW];
                sel_h   = bus.rect_h[i*DW +: DW];
                sel_col = bus.rect_colour[i*CW +: CW];
            end
        end
    end

    assign w_clamp  = (sel_w > DW'(MAXDIM)) ? DW'(MAXDIM) : sel_w;
    assign h_clamp  = (sel_h > DW'(MAXDIM)) ? DW'(MAXDIM) : sel_h;
    assign last_col = (cx_q == w_q - DW'(1));
    assign last_pix = last_col && (cy_q == h_q - DW'(1));

    // The pixel registers always hold the pixel being shown, so the next one is computed a cycle ahead.
    assign nxt_cx   = (state_q == ST_LOAD || last_col) ? '0 : cx_q + DW'(1);
    assign nxt_cy   = (state_q == ST_LOAD) ? '0 : (last_col ? cy_q + DW'(1) : cy_q);
    assign base_x   = (state_q == ST_LOAD) ? sel_x : x_q;
    assign base_y   = (state_q == ST_LOAD) ? sel_y : y_q;
    assign base_col = (state_q == ST_LOAD) ? sel_col : col_q;
    assign sum_x    = {1'b0, base_x} + (XW+1)'(nxt_cx);
    assign sum_y    = {1'b0, base_y} + (YW+1)'(nxt_cy);
    assign pix_on   = (sum_x < (XW+1)'(XSCREEN)) && (sum_y < (YW+1)'(YSCREEN));

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        x_d       = x_q;
        y_d       = y_q;
        w_d       = w_q;
        h_d       = h_q;
        col_d     = col_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        vga_x_d   = vga_x_q;
        vga_y_d   = vga_y_q;
        vga_col_d = vga_col_q;
        plot_d    = 1'b0;
        emit      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    state_d = ST_LOAD;
                    grant_d = rr_pick;
                end
            end
            ST_LOAD: begin
                x_d   = sel_x;
                y_d   = sel_y;
                w_d   = w_clamp;
                h_d   = h_clamp;
                col_d = sel_col;
                cx_d  = '0;
                cy_d  = '0;
                if (w_clamp == '0 || h_clamp == '0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAW;
                    emit    = 1'b1;
                end
            end
            ST_DRAW: begin
                if (last_pix) begin
                    state_d = ST_DONE;
                end else begin
                    cx_d = nxt_cx;
                    cy_d = nxt_cy;
                    emit = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = '0;
                last_d  = grant_q;
            end
            default: state_d = ST_IDLE;
        endcase
        if (emit) begin
            vga_x_d = sum_x[XW-1:0];
            vga_y_d = sum_y[YW-1:0];
            plot_d  = pix_on;
            if (pix_on) vga_col_d = base_col;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_q       <= '0;
            last_q[NREQ-1] <= 1'b1;
            x_q          <= '0;
            y_q          <= '0;
            w_q          <= '0;
            h_q          <= '0;
            col_q        <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_col_q    <= '0;
            plot_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
            x_q          <= x_d;
            y_q          <= y_d;
            w_q          <= w_d;
            h_q          <= h_d;
            col_q        <= col_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_col_q    <= vga_col_d;
            plot_q       <= plot_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.done       = (state_q == ST_DONE) ? grant_q : '0;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_col_q;
    assign bus.vga_plot   = plot_q;

endmodule

// File: tb/tb_vga_rect_arbiter.sv
// tb/tb_vga_rect_arbiter.sv - directed bench with a per-cycle reference model of the rectangle arbiter
module tb_vga_rect_arbiter;
    import vga_pkg::*;

    localparam int NREQ = 3;
    localparam int DW   = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_rect_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    vga_rect_arbiter #(.NREQ(NREQ), .MAXDIM(16), .DW(DW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        int kind;   // 0 idle, 1 load, 2 draw, 3 done
        int g;
        bit plot;
        int x;
        int y;
        int col;
    } ent_t;

    ent_t q[$];
    int   dlog[$];
    int   m_last = NREQ - 1;
    int   m_col = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   plot_cnt = 0;
    int   done_cnt = 0;
    int   first_plot_cyc = -1;
    int   last_done_cyc = -1;
    bit   seen_plot = 1'b0;

    function automatic int clampd(int v);
        return (v > 16) ? 16 : v;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic cycle_check();
        ent_t e;
        logic [NREQ-1:0] eg, ed;
        int x, y, w, h, c, rc, sx, sy;
        if (rst) begin
            n_vec++;
            if (bus.grant !== '0 || bus.done !== '0 || bus.busy !== 1'b0 || bus.vga_plot !== 1'b0 ||
                bus.vga_x !== '0 || bus.vga_y !== '0 || bus.vga_colour !== '0) begin
                n_err++;
                $display("FAIL reset_outputs cycle %0d: grant=%b done=%b busy=%b plot=%b x=%0d y=%0d col=%0d, expected all 0",
                         cyc, bus.grant, bus.done, bus.busy, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour);
            end
            q.delete();
            m_last    = NREQ - 1;
            m_col     = 0;
            seen_plot = 1'b0;
            return;
        end
        if (q.size() == 0) begin
            e.kind = 0; e.g = 0; e.plot = 1'b0; e.x = 0; e.y = 0; e.col = m_col;
        end else begin
            e = q.pop_front();
        end
        eg = '0;
        if (e.kind != 0) eg[e.g] = 1'b1;
        ed = (e.kind == 3) ? eg : '0;
        n_vec++;
        if (bus.grant !== eg || bus.done !== ed || bus.busy !== (e.kind != 0) || bus.vga_plot !== e.plot ||
            bus.vga_colour !== 3'(e.col) || (e.kind == 2 && (bus.vga_x !== 8'(e.x) || bus.vga_y !== 7'(e.y)))) begin
            n_err++;
            $display("FAIL model cycle %0d: got grant=%b done=%b busy=%b plot=%b x=%0d y=%0d col=%0d, expected grant=%b done=%b busy=%b plot=%b x=%0d y=%0d col=%0d",
                     cyc, bus.grant, bus.done, bus.busy, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour,
                     eg, ed, (e.kind != 0), e.plot, e.x, e.y, e.col);
        end
        if (bus.vga_plot) begin
            plot_cnt++;
            if (!seen_plot) first_plot_cyc = cyc;
            seen_plot = 1'b1;
        end
        if (!bus.busy) seen_plot = 1'b0;
        if (bus.done != '0) begin
            done_cnt++;
            last_done_cyc = cyc;
            for (int i = 0; i < NREQ; i++) if (bus.done[i]) dlog.push_back(i);
        end
        m_col = e.col;
        if (e.kind == 0 && bus.req != '0) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (bus.req[(m_last + k) % NREQ] && e.kind == 0) begin
                    e.kind = 1;
                    e.g    = (m_last + k) % NREQ;
                end
            end
            e.plot = 1'b0;
            e.col  = m_col;
            q.push_back(e);
        end else if (e.kind == 1) begin
            x  = int'(bus.rect_x[e.g*8 +: 8]);
            y  = int'(bus.rect_y[e.g*7 +: 7]);
            w  = clampd(int'(bus.rect_w[e.g*DW +: DW]));
            h  = clampd(int'(bus.rect_h[e.g*DW +: DW]));
            c  = int'(bus.rect_colour[e.g*3 +: 3]);
            rc = m_col;
            for (int r = 0; r < h; r++) begin
                for (int cc = 0; cc < w; cc++) begin
                    sx = x + cc;
                    sy = y + r;
                    e.kind = 2;
                    e.plot = (sx < 160) && (sy < 120);
                    if (e.plot) rc = c;
                    e.x = sx % 256;
                    e.y = sy % 128;
                    e.col = rc;
                    q.push_back(e);
                end
            end
            e.kind = 3; e.plot = 1'b0; e.col = rc;
            q.push_back(e);
        end else if (e.kind == 3) begin
            m_last = e.g;
        end
    endtask

    task automatic step();
        @(negedge clk);
        cycle_check();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic set_rect(input int i, input int x, input int y, input int w, input int h, input int c);
        bus.rect_x[i*8 +: 8]       = 8'(x);
        bus.rect_y[i*7 +: 7]       = 7'(y);
        bus.rect_w[i*DW +: DW]     = DW'(w);
        bus.rect_h[i*DW +: DW]     = DW'(h);
        bus.rect_colour[i*3 +: 3]  = 3'(c);
    endtask

    task automatic wait_done(input string nm, input int maxc);
        int d0 = done_cnt;
        for (int i = 0; i < maxc && done_cnt == d0; i++) step();
        if (done_cnt == d0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: no done within %0d cycles, expected one", nm, maxc);
        end
    endtask

    task automatic wait_plots(input string nm, input int p0, input int n, input int maxc);
        for (int i = 0; i < maxc && (plot_cnt - p0) < n; i++) step();
        if ((plot_cnt - p0) < n) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: %0d plots seen, expected %0d", nm, plot_cnt - p0, n);
        end
    endtask

    int p0, d0, start;
    int exp_order[4] = '{0, 1, 2, 0};

    initial begin
        bus.req = '0; bus.rect_x = '0; bus.rect_y = '0;
        bus.rect_w = '0; bus.rect_h = '0; bus.rect_colour = '0;
        rst = 1'b1;
        #1;
        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();

        // single 10x10 apple rectangle
        set_rect(2, 80, 60, 10, 10, 4);
        p0 = plot_cnt; start = cyc;
        bus.req = 3'b100;
        wait_done("single", 200);
        bus.req = '0;
        chk("single_pixels", plot_cnt - p0, 100);
        chk("single_first_latency", first_plot_cyc - start, 2);
        chk("single_done_latency", last_done_cyc - start, 102);
        chk("single_done_idx", dlog[$], 2);
        repeat (2) step();

        // contention, all 2x2, last served was 2
        set_rect(0, 0, 0, 2, 2, 1);
        set_rect(1, 10, 0, 2, 2, 2);
        set_rect(2, 20, 0, 2, 2, 3);
        d0 = dlog.size();
        bus.req = 3'b111;
        repeat (4) wait_done("contention", 20);
        bus.req = '0;
        for (int k = 0; k < 4; k++) begin
            if (dlog.size() > d0 + k) chk($sformatf("contention_order%0d", k), dlog[d0 + k], exp_order[k]);
            else chk($sformatf("contention_order%0d_missing", k), -1, exp_order[k]);
        end
        repeat (2) step();

        // clipping at bottom-right corner
        set_rect(0, 155, 117, 10, 5, 2);
        p0 = plot_cnt; start = cyc;
        bus.req = 3'b001;
        wait_done("clip", 100);
        bus.req = '0;
        chk("clip_pixels", plot_cnt - p0, 15);
        chk("clip_done_latency", last_done_cyc - start, 52);
        chk("clip_done_idx", dlog[$], 0);
        repeat (2) step();

        // zero width
        set_rect(1, 40, 40, 0, 7, 6);
        p0 = plot_cnt; start = cyc;
        bus.req = 3'b010;
        wait_done("zero", 20);
        bus.req = '0;
        chk("zero_pixels", plot_cnt - p0, 0);
        chk("zero_done_latency", last_done_cyc - start, 2);
        repeat (2) step();

        // width clamp
        set_rect(2, 10, 5, 31, 1, 7);
        p0 = plot_cnt; start = cyc;
        bus.req = 3'b100;
        wait_done("clamp", 50);
        bus.req = '0;
        chk("clamp_pixels", plot_cnt - p0, 16);
        chk("clamp_done_latency", last_done_cyc - start, 18);
        repeat (2) step();

        // reset during DRAW
        set_rect(1, 20, 20, 4, 4, 3);
        p0 = plot_cnt; d0 = done_cnt;
        bus.req = 3'b010;
        wait_plots("reset_mid", p0, 5, 30);
        rst = 1'b1;
        step();
        step();
        chk("reset_no_done", done_cnt - d0, 0);
        set_rect(0, 1, 1, 1, 1, 5);
        set_rect(1, 2, 2, 1, 1, 6);
        set_rect(2, 3, 3, 1, 1, 7);
        bus.req = 3'b111;
        rst = 1'b0;
        wait_done("post_reset", 20);
        bus.req = '0;
        chk("post_reset_first_grant", dlog[$], 0);
        repeat (2) step();

        // origin change and req drop mid-DRAW
        set_rect(0, 30, 40, 3, 3, 5);
        p0 = plot_cnt;
        bus.req = 3'b001;
        wait_plots("middraw", p0, 2, 20);
        bus.rect_x[7:0] = 8'd100;
        bus.req = '0;
        wait_done("middraw", 20);
        chk("middraw_pixels", plot_cnt - p0, 9);
        chk("middraw_done_idx", dlog[$], 0);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
